// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter and related UART blocks.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWaitBusy,
    StWaitDone
  } uart_arb_state_t;

  localparam int unsigned UART_DATA_WIDTH = 8;

  function automatic int unsigned uart_idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: rotate the eligible vector to the pointer, take the lowest set bit, and
// map the offset back to an absolute index.
module uart_rr_pick #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = 2
) (
  input  logic [NumReq-1:0] eligible_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [IdxW-1:0]   winner_o,
  output logic              any_valid_o
);

  logic [NumReq-1:0] rotated;
  logic [IdxW-1:0]   offset;
  logic [IdxW-1:0]   src_idx;

  always_comb begin
    rotated = '0;
    src_idx = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      src_idx    = IdxW'((i + int'(ptr_i)) % NumReq);
      rotated[i] = eligible_i[src_idx];
    end
  end

  // Descending scan so the smallest offset from the pointer is the last one written.
  always_comb begin
    offset      = '0;
    any_valid_o = 1'b0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        offset      = IdxW'(i);
        any_valid_o = 1'b1;
      end
    end
  end

  assign winner_o = IdxW'((int'(offset) + int'(ptr_i)) % NumReq);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters.
// Define UART_ARB_LOCK_EN to keep multi-byte packets (closed by req_last) from interleaving.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_start,
  input  logic                          tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          grant_valid
);

  localparam int unsigned IdxW = uart_idx_width(NUM_REQ);

  uart_arb_state_t        state_q, state_d;
  logic [IdxW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]        grant_id_q, grant_id_d;
  logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
  logic                   grant_valid_q, grant_valid_d;
  logic [NUM_REQ-1:0]     eligible;
  logic [IdxW-1:0]        winner;
  logic                   any_valid;
  logic [IdxW-1:0]        next_ptr;

`ifdef UART_ARB_LOCK_EN
  logic lock_q, lock_d;
  logic last_q, last_d;

  // While locked only the packet owner may be granted.
  assign eligible = lock_q ? (req_valid & ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_q))
                           : req_valid;
`else
  logic unused_last;

  assign unused_last = ^req_last;
  assign eligible    = req_valid;
`endif

  assign next_ptr = (grant_id_q == IdxW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

  uart_rr_pick #(
    .NumReq (NUM_REQ),
    .IdxW   (IdxW)
  ) u_pick (
    .eligible_i  (eligible),
    .ptr_i       (rr_ptr_q),
    .winner_o    (winner),
    .any_valid_o (any_valid)
  );

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    tx_data_d     = tx_data_q;
    grant_valid_d = grant_valid_q;
    req_ready     = '0;
    tx_start      = 1'b0;
`ifdef UART_ARB_LOCK_EN
    lock_d        = lock_q;
    last_d        = last_q;
`endif
    case (state_q)
      StIdle: begin
        if (!rst && !tx_busy && any_valid) begin
          req_ready[winner] = 1'b1;
          tx_data_d         = req_data[int'(winner) * DATA_WIDTH +: DATA_WIDTH];
          grant_id_d        = winner;
          grant_valid_d     = 1'b1;
`ifdef UART_ARB_LOCK_EN
          last_d            = req_last[winner];
`endif
          state_d           = StStart;
        end
      end
      StStart: begin
        tx_start = 1'b1;
        state_d  = StWaitBusy;
      end
      StWaitBusy: begin
        if (tx_busy) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (!tx_busy) begin
          grant_valid_d = 1'b0;
          state_d       = StIdle;
`ifdef UART_ARB_LOCK_EN
          lock_d = !last_q;
          if (last_q) rr_ptr_d = next_ptr;
`else
          rr_ptr_d = next_ptr;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      tx_data_q     <= '0;
      grant_valid_q <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      lock_q        <= 1'b0;
      last_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      tx_data_q     <= tx_data_d;
      grant_valid_q <= grant_valid_d;
`ifdef UART_ARB_LOCK_EN
      lock_q        <= lock_d;
      last_q        <= last_d;
`endif
    end
  end

  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;
  assign grant_valid = grant_valid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-lane byte queues, a transmitter model and a round-robin
// reference that predicts every output on every cycle.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } item_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   tx_data;
  logic           tx_start;
  logic           tx_busy = 1'b0;
  logic [1:0]     grant_id;
  logic           grant_valid;

  uart_tx_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  item_t lane_q [N][$];

  // Transmitter model and stimulus knobs.
  int tx_cnt = 0;
  bit prev_start = 0;
  int fl_min = 1;
  int fl_max = 5;
  bit force_busy = 0;
  bit rst_nxt = 1;

  // Observed outputs, sampled mid-cycle.
  logic [N-1:0] s_ready;
  logic         s_start, s_gv;
  logic [W-1:0] s_data;
  logic [1:0]   s_gid;

  // Reference model state and its per-cycle prediction.
  int           m_ptr = 0;
  int           m_lock_lane = -1;
  bit           m_free = 1;
  int           m_k = 0;
  bit           m_seen = 0;
  logic [1:0]   m_gid = '0;
  logic [W-1:0] m_data = '0;
  logic [N-1:0] e_ready;
  logic         e_start, e_gv;
  logic [W-1:0] e_data;
  logic [1:0]   e_gid;
  int           acc_lane;

  task automatic cycle();
    int w;
    int lane;
    @(posedge clk);
    #1;
    rst = rst_nxt;
    for (int i = 0; i < N; i++) begin
      if (s_ready[i] === 1'b1 && lane_q[i].size() > 0) void'(lane_q[i].pop_front());
    end
    if (prev_start) tx_cnt = $urandom_range(fl_max, fl_min);
    else if (tx_cnt > 0) tx_cnt--;
    tx_busy = (tx_cnt > 0) || force_busy;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = lane_q[i].size() > 0;
      req_data[i*W +: W] = req_valid[i] ? lane_q[i][0].data : '0;
      req_last[i] = req_valid[i] ? lane_q[i][0].last : 1'b0;
    end
    #4;
    s_ready = req_ready;
    s_start = tx_start;
    s_data = tx_data;
    s_gid = grant_id;
    s_gv = grant_valid;
    prev_start = (tx_start === 1'b1);

    e_start = !m_free && (m_k == 1);
    e_gv = !m_free;
    e_gid = m_gid;
    e_data = m_data;
    e_ready = '0;
    w = -1;
    if (!rst && m_free && !tx_busy) begin
      for (int k = 0; k < N; k++) begin
        lane = (m_ptr + k) % N;
        if (w < 0 && req_valid[lane] && (m_lock_lane < 0 || m_lock_lane == lane)) w = lane;
      end
    end
    acc_lane = w;
    if (w >= 0) begin
      e_ready[w] = 1'b1;
      m_free = 0;
      m_k = 1;
      m_seen = 0;
      m_gid = 2'(w);
      m_data = lane_q[w][0].data;
`ifdef UART_ARB_LOCK_EN
      if (lane_q[w][0].last) begin
        m_lock_lane = -1;
        m_ptr = (w + 1) % N;
      end else begin
        m_lock_lane = w;
      end
`else
      m_ptr = (w + 1) % N;
`endif
    end else if (!m_free) begin
      if (m_k == 1) m_k = 2;
      else if (!m_seen) begin
        if (tx_busy) m_seen = 1;
      end else if (!tx_busy) m_free = 1;
    end
    if (rst) begin
      m_ptr = 0;
      m_lock_lane = -1;
      m_free = 1;
      m_gid = '0;
      m_data = '0;
    end
  endtask

  task automatic do_reset();
    force_busy = 0;
    rst_nxt = 1;
    for (int i = 0; i < N; i++) lane_q[i].delete();
    repeat (8) cycle();
    rst_nxt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    cycle();
    checks++;
    if (s_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b want 0", s_ready); end
    checks++;
    if (s_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", s_start); end
    checks++;
    if (s_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 00", s_data); end
    checks++;
    if (s_gid !== '0) begin errors++; $display("FAIL reset_gid: got %0d want 0", s_gid); end
    checks++;
    if (s_gv !== 1'b0) begin errors++; $display("FAIL reset_gv: got %b want 0", s_gv); end
  endtask

  task automatic test_single_lane();
    do_reset();
    lane_q[2].push_back('{data: 8'h41, last: 1'b1});
    cycle();
    checks++;
    if (s_ready !== 4'b0100) begin
      errors++; $display("FAIL single_ready: got %b want 0100", s_ready);
    end
    cycle();
    checks++;
    if ({s_start, s_data, s_gid} !== {1'b1, 8'h41, 2'd2}) begin
      errors++;
      $display("FAIL single_start: got start=%b data=%h gid=%0d want 1 41 2", s_start, s_data,
               s_gid);
    end
    for (int t = 0; t < 30 && !m_free; t++) begin
      cycle();
      checks++;
      if ({s_ready, s_start, s_data, s_gid, s_gv} !== {e_ready, e_start, e_data, e_gid, e_gv}) begin
        errors++;
        $display("FAIL single_model: got %h want %h", {s_ready, s_start, s_data, s_gid, s_gv},
                 {e_ready, e_start, e_data, e_gid, e_gv});
      end
    end
  endtask

  task automatic test_all_lanes();
    int order[$];
    int exp_ord[5] = '{0, 1, 2, 3, 0};
    do_reset();
    fl_min = 3;
    fl_max = 3;
    for (int i = 0; i < N; i++) begin
      repeat (2) lane_q[i].push_back('{data: 8'($urandom), last: 1'b1});
    end
    for (int t = 0; t < 200 && order.size() < 8; t++) begin
      cycle();
      if (acc_lane >= 0) order.push_back(acc_lane);
      checks++;
      if ({s_ready, s_start, s_data, s_gid, s_gv} !== {e_ready, e_start, e_data, e_gid, e_gv}) begin
        errors++;
        $display("FAIL all_lanes_model: got %h want %h", {s_ready, s_start, s_data, s_gid, s_gv},
                 {e_ready, e_start, e_data, e_gid, e_gv});
      end
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= order.size()) begin
        errors++; $display("FAIL all_lanes_order[%0d]: got none want %0d", i, exp_ord[i]);
      end else if (order[i] != exp_ord[i]) begin
        errors++; $display("FAIL all_lanes_order[%0d]: got %0d want %0d", i, order[i], exp_ord[i]);
      end
    end
  endtask

  task automatic test_mid_frame();
    int t_fall = -1;
    int t_acc1 = -1;
    bit pushed = 0;
    bit seen_busy = 0;
    do_reset();
    fl_min = 5;
    fl_max = 5;
    lane_q[0].push_back('{data: 8'h30, last: 1'b1});
    for (int t = 0; t < 60 && t_acc1 < 0; t++) begin
      cycle();
      checks++;
      if ({s_ready, s_start, s_data, s_gid, s_gv} !== {e_ready, e_start, e_data, e_gid, e_gv}) begin
        errors++;
        $display("FAIL mid_frame_model: got %h want %h", {s_ready, s_start, s_data, s_gid, s_gv},
                 {e_ready, e_start, e_data, e_gid, e_gv});
      end
      if (pushed && tx_busy) seen_busy = 1;
      if (seen_busy && !tx_busy && t_fall < 0) t_fall = t;
      if (s_ready[1] === 1'b1) t_acc1 = t;
      if (!pushed && tx_busy && s_gv) begin
        lane_q[1].push_back('{data: 8'h31, last: 1'b1});
        pushed = 1;
        seen_busy = 1;
      end
    end
    checks++;
    if (t_fall < 0 || t_acc1 != t_fall + 1) begin
      errors++; $display("FAIL mid_frame_latency: got accept at %0d want %0d", t_acc1, t_fall + 1);
    end
  endtask

  task automatic test_busy_at_idle();
    int nready = 0;
    do_reset();
    force_busy = 1;
    lane_q[1].push_back('{data: 8'h5a, last: 1'b1});
    repeat (10) begin
      cycle();
      if (s_ready !== '0) nready++;
    end
    checks++;
    if (nready != 0) begin errors++; $display("FAIL busy_idle_hold: got %0d accepts want 0", nready); end
    force_busy = 0;
    cycle();
    checks++;
    if (s_ready !== 4'b0010) begin
      errors++; $display("FAIL busy_idle_release: got %b want 0010", s_ready);
    end
    for (int t = 0; t < 30 && !m_free; t++) begin
      cycle();
      checks++;
      if ({s_ready, s_start, s_data, s_gid, s_gv} !== {e_ready, e_start, e_data, e_gid, e_gv}) begin
        errors++;
        $display("FAIL busy_idle_model: got %h want %h", {s_ready, s_start, s_data, s_gid, s_gv},
                 {e_ready, e_start, e_data, e_gid, e_gv});
      end
    end
  endtask

  task automatic test_reset_in_wait_done();
    int first = -1;
    do_reset();
    fl_min = 2;
    fl_max = 2;
    lane_q[1].push_back('{data: 8'h11, last: 1'b1});
    for (int t = 0; t < 30 && !(t > 2 && m_free); t++) cycle();
    // Lane 2 frame is then abandoned in its busy phase; the pointer would otherwise favour lane 3.
    fl_min = 10;
    fl_max = 10;
    lane_q[2].push_back('{data: 8'h22, last: 1'b1});
    for (int t = 0; t < 20 && !(tx_busy && m_seen); t++) cycle();
    cycle();
    lane_q[0].push_back('{data: 8'h00, last: 1'b1});
    lane_q[3].push_back('{data: 8'h33, last: 1'b1});
    rst_nxt = 1;
    cycle();
    rst_nxt = 0;
    cycle();
    checks++;
    if ({s_ready, s_start, s_gv, s_gid, s_data} !== '0) begin
      errors++;
      $display("FAIL rst_wait_done: got ready=%b start=%b gv=%b gid=%0d data=%h want all 0", s_ready,
               s_start, s_gv, s_gid, s_data);
    end
    for (int t = 0; t < 30 && first < 0; t++) begin
      cycle();
      if (acc_lane >= 0) first = acc_lane;
      checks++;
      if ({s_ready, s_start, s_data, s_gid, s_gv} !== {e_ready, e_start, e_data, e_gid, e_gv}) begin
        errors++;
        $display("FAIL rst_wait_done_model: got %h want %h", {s_ready, s_start, s_data, s_gid, s_gv},
                 {e_ready, e_start, e_data, e_gid, e_gv});
      end
    end
    checks++;
    if (first != 0 || s_ready !== 4'b0001) begin
      errors++; $display("FAIL rst_wait_done_winner: got %0d (%b) want 0", first, s_ready);
    end
  endtask

`ifdef UART_ARB_LOCK_EN
  task automatic test_packet_lock();
    int lanes[$];
    logic [W-1:0] datas[$];
    int exp_l[4] = '{3, 3, 3, 0};
    logic [W-1:0] exp_d[4] = '{8'h10, 8'h11, 8'h12, 8'h55};
    do_reset();
    fl_min = 2;
    fl_max = 4;
    lane_q[3].push_back('{data: 8'h10, last: 1'b0});
    lane_q[3].push_back('{data: 8'h11, last: 1'b0});
    lane_q[3].push_back('{data: 8'h12, last: 1'b1});
    for (int t = 0; t < 200 && lanes.size() < 4; t++) begin
      cycle();
      if (acc_lane >= 0) begin
        lanes.push_back(acc_lane);
        datas.push_back(req_data[acc_lane*W +: W]);
        if (lanes.size() == 1) lane_q[0].push_back('{data: 8'h55, last: 1'b1});
      end
      checks++;
      if ({s_ready, s_start, s_data, s_gid, s_gv} !== {e_ready, e_start, e_data, e_gid, e_gv}) begin
        errors++;
        $display("FAIL lock_model: got %h want %h", {s_ready, s_start, s_data, s_gid, s_gv},
                 {e_ready, e_start, e_data, e_gid, e_gv});
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= lanes.size() || lanes[i] != exp_l[i] || datas[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL lock_order[%0d]: got lane %0d data %h want lane %0d data %h", i,
                 (i < lanes.size()) ? lanes[i] : -1, (i < datas.size()) ? datas[i] : 8'hxx,
                 exp_l[i], exp_d[i]);
      end
    end
  endtask
`endif

  task automatic test_random();
    int wait_f[N] = '{default: 0};
    int max_wait = 0;
    int naccept = 0;
    do_reset();
    fl_min = 1;
    fl_max = 6;
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(7, 0) == 0 && lane_q[i].size() < 4)
          lane_q[i].push_back('{data: 8'($urandom), last: ($urandom_range(2, 0) == 0)});
      end
      cycle();
      checks++;
      if ({s_ready, s_start, s_data, s_gid, s_gv} !== {e_ready, e_start, e_data, e_gid, e_gv}) begin
        errors++;
        $display("FAIL random_model t=%0d: got %h want %h", t, {s_ready, s_start, s_data, s_gid,
                 s_gv}, {e_ready, e_start, e_data, e_gid, e_gv});
      end
      if (acc_lane >= 0) begin
        naccept++;
        for (int i = 0; i < N; i++) begin
          if (i == acc_lane) wait_f[i] = 0;
          else if (req_valid[i]) begin
            wait_f[i]++;
            if (wait_f[i] > max_wait) max_wait = wait_f[i];
          end
        end
      end
    end
    checks++;
    if (naccept < 50) begin errors++; $display("FAIL random_progress: got %0d want >=50", naccept); end
`ifndef UART_ARB_LOCK_EN
    checks++;
    if (max_wait > N - 1) begin
      errors++; $display("FAIL random_starve: got %0d frames want <=%0d", max_wait, N - 1);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_lane();
    test_all_lanes();
    test_mid_frame();
    test_busy_at_idle();
    test_reset_in_wait_done();
`ifdef UART_ARB_LOCK_EN
    test_packet_lock();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter among NUM_REQ byte-stream requesters, such as the debug console, CPU MMIO port and DMA logger. It accepts bytes on per-requester valid/ready lanes, issues each byte to the transmitter with a one-cycle start strobe, and waits for the frame to finish before granting again. Bit timing stays inside the transmitter, which runs from the baud generator's tick. Optional packet locking keeps multi-byte messages from interleaving.

## Interface
- NUM_REQ, 4: number of requesters; legal range 2..8.
- DATA_WIDTH, 8: byte width; must match the transmitter.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-lane byte available.
- req_data  in  NUM_REQ*DATA_WIDTH  lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  in  NUM_REQ  byte ends a packet; used only with locking.
- req_ready  out  NUM_REQ  one-hot accept strobe; combinational.
- tx_data  out  DATA_WIDTH  registered byte to the transmitter.
- tx_start  out  1  one-cycle start pulse.
- tx_busy  in  1  transmitter busy with a frame.
- grant_id  out  $clog2(NUM_REQ)  owner of the current or last frame.
- grant_valid  out  1  high from accept until the frame completes.

## Operation
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Acts only when tx_busy=0 and at least one eligible lane has req_valid.
  - Winner is the first valid lane at or after rr_ptr, searching upward with wrap from NUM_REQ-1 to 0.
  - req_ready[winner]=1 in that same cycle. tx_data, grant_id and last_q are latched, grant_valid is set, and the FSM moves to START.
- START: tx_start=1 for exactly one cycle, then WAIT_BUSY.
- WAIT_BUSY: hold until tx_busy=1, then WAIT_DONE.
- WAIT_DONE: hold until tx_busy=0. Then clear grant_valid, set rr_ptr to grant_id+1 (wrapping at NUM_REQ), and go to IDLE.
- Requester rule: once req_valid is asserted, req_data and req_last stay stable and req_valid stays high until req_ready. Dropping valid early is a protocol violation with undefined results.
- Exactly one req_ready bit is high, for exactly one cycle, per accepted byte.
- tx_data holds its value from accept until the next accept.
- Simultaneous valids: the lane nearest rr_ptr wins; no lane starves longer than NUM_REQ-1 frames.
- A valid raised during a frame waits for the next IDLE. It is never accepted mid-frame.
- rst at any cycle:
  - FSM goes to IDLE and rr_ptr to 0; the lock clears.
  - All outputs take their reset values next cycle. An in-flight frame is abandoned without a tx_start retry.
- Reset values: req_ready=0, tx_start=0, tx_data=0, grant_id=0, grant_valid=0.

## Timing
- Accept to tx_start: 1 cycle. Accept at cycle t gives tx_start at t+1.
- Transmitter contract: tx_busy rises by t+2 and falls when the frame ends.
- Frame end to next accept: tx_busy low at cycle f gives IDLE at f+1, accept at f+1, tx_start at f+2.
- Throughput: one byte per transmitter frame plus 2 cycles of overhead.

## Configuration
- UART_ARB_LOCK_EN defined:
  - After a byte accepted with req_last=0, only that lane is eligible in IDLE. Other lanes are masked even when valid.
  - The lock releases when a byte with req_last=1 completes.
  - rr_ptr advances only on lock release.
- UART_ARB_LOCK_EN undefined:
  - req_last is ignored.
  - Every byte is arbitrated independently and rr_ptr advances after every frame.

## Structure
- Shared package uart_pkg holds:
  - the FSM state enum (uart_arb_state_t);
  - the UART_DATA_WIDTH constant;
  - the grant index width function.
- Sub-module uart_rr_pick: combinational rotate, priority-encode, un-rotate. Inputs are the eligible vector and rr_ptr; outputs are winner index and any_valid. It is reusable by a later RX-side dispatcher.

## Test plan
- Single lane: lane 2 valid with 0x41 while tx_busy=0 → req_ready[2] at t, tx_start with tx_data=0x41 at t+1, grant_id=2.
- All four lanes valid continuously from reset → grant order 0,1,2,3,0, each separated by a full tx_busy frame.
- Lane 1 raises valid mid-frame of lane 0 → no req_ready until WAIT_DONE sees tx_busy=0, then lane 1 is accepted one cycle later.
- UART_ARB_LOCK_EN, lane 3 sends 0x10/0x11/0x12 with last on 0x12 while lane 0 is valid → all three lane-3 bytes go back-to-back, then lane 0 is granted.
- Reset asserted in WAIT_DONE → next cycle: IDLE, grant_valid=0, tx_start=0, rr_ptr=0, lock cleared. A pending lane 0 is accepted once tx_busy is low.
- tx_busy held high at idle with lane 1 valid → no accept until tx_busy falls.
